// File: rtl/alert_handler_reg_pkg.sv
// rtl/alert_handler_reg_pkg.sv - shared widths, state encoding and counter helper for the escalation timer
package alert_handler_reg_pkg;

  localparam int AccuCntDw = 16;
  localparam int EscCntDw  = 32;
  localparam int N_PHASES  = 4;
  localparam int N_ESC_SEV = 4;
  localparam int PHASE_DW  = 2;

  // Phase states carry their phase index in the low two bits.
  typedef enum logic [2:0] {
    Idle     = 3'b000,
    Timeout  = 3'b001,
    Terminal = 3'b011,
    Phase0   = 3'b100,
    Phase1   = 3'b101,
    Phase2   = 3'b110,
    Phase3   = 3'b111
  } cstate_e;

  function automatic logic [EscCntDw-1:0] esc_cnt_inc(input logic [EscCntDw-1:0] c);
    return (&c) ? c : c + EscCntDw'(1);
  endfunction

endpackage

// File: rtl/alert_handler_esc_timer_if.sv
// rtl/alert_handler_esc_timer_if.sv - trigger, configuration and escalation-status bundle of one class
interface alert_handler_esc_timer_if
  import alert_handler_reg_pkg::*;
#(
  parameter int AccuW = AccuCntDw
);

  logic                          en_i;
  logic                          clr_i;
  logic                          class_trig_i;
  logic [AccuW-1:0]              accu_thresh_i;
  logic [EscCntDw-1:0]           timeout_cyc_i;
  logic [N_PHASES*EscCntDw-1:0]  phase_cyc_i;
  logic [N_ESC_SEV*PHASE_DW-1:0] esc_map_i;
  logic [N_ESC_SEV-1:0]          esc_en_i;
  logic [AccuW-1:0]              accu_cnt_o;
  logic [EscCntDw-1:0]           esc_cnt_o;
  logic [2:0]                    esc_state_o;
  logic                          esc_trig_o;
  logic [N_ESC_SEV-1:0]          esc_sig_o;

  modport master (
    output en_i, clr_i, class_trig_i, accu_thresh_i, timeout_cyc_i, phase_cyc_i, esc_map_i, esc_en_i,
    input  accu_cnt_o, esc_cnt_o, esc_state_o, esc_trig_o, esc_sig_o
  );

  modport slave (
    input  en_i, clr_i, class_trig_i, accu_thresh_i, timeout_cyc_i, phase_cyc_i, esc_map_i, esc_en_i,
    output accu_cnt_o, esc_cnt_o, esc_state_o, esc_trig_o, esc_sig_o
  );

endinterface

// File: rtl/alert_handler_accu.sv
// rtl/alert_handler_accu.sv - saturating trigger accumulator with threshold compare
module alert_handler_accu
  import alert_handler_reg_pkg::*;
#(
  parameter int AccuW = AccuCntDw
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             trig_q,
  input  logic [AccuW-1:0] accu_thresh_i,
  output logic [AccuW-1:0] accu_cnt_o,
  output logic             accu_trig
);

  logic [AccuW-1:0] accu_cnt_q, accu_cnt_d;

  always_comb begin
    accu_cnt_d = accu_cnt_q;
    if (clr_i) begin
      accu_cnt_d = '0;
    end else if (trig_q && !(&accu_cnt_q)) begin
      accu_cnt_d = accu_cnt_q + AccuW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      accu_cnt_q <= '0;
    end else begin
      accu_cnt_q <= accu_cnt_d;
    end
  end

  // Compare against the pre-increment count: threshold N escalates on trigger N+1.
  assign accu_trig  = trig_q & (accu_cnt_q >= accu_thresh_i);
  assign accu_cnt_o = accu_cnt_q;

endmodule

// File: rtl/alert_handler_esc_timer.sv
// rtl/alert_handler_esc_timer.sv - per-class escalation FSM; ESC_CLR_LOCK_EN makes clear ineffective once escalation starts
module alert_handler_esc_timer
  import alert_handler_reg_pkg::*;
#(
  parameter int AccuW = AccuCntDw
) (
  input logic                      clk_i,
  input logic                      rst_ni,
  alert_handler_esc_timer_if.slave bus
);

  cstate_e             state_q;
  logic [EscCntDw-1:0] esc_cnt_q;
  logic                esc_trig_q;
  logic                trig_q;
  logic                clr_eff;
  logic                accu_trig;
  logic                go_p0;
  logic [EscCntDw-1:0] phase_len, phase_lim, timeout_lim;
  logic [N_ESC_SEV-1:0] esc_sig;

  assign trig_q = bus.en_i & bus.class_trig_i;

`ifdef ESC_CLR_LOCK_EN
  logic lock_q;
  assign clr_eff = bus.clr_i & ~lock_q;
`else
  assign clr_eff = bus.clr_i;
`endif

  alert_handler_accu #(
    .AccuW(AccuW)
  ) u_accu (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .clr_i        (clr_eff),
    .trig_q       (trig_q),
    .accu_thresh_i(bus.accu_thresh_i),
    .accu_cnt_o   (bus.accu_cnt_o),
    .accu_trig    (accu_trig)
  );

  // A programmed length of 0 behaves like 1 so every phase lasts at least a cycle.
  always_comb begin
    phase_len   = bus.phase_cyc_i[32'(state_q[1:0]) * EscCntDw +: EscCntDw];
    phase_lim   = (phase_len == '0) ? '0 : phase_len - EscCntDw'(1);
    timeout_lim = bus.timeout_cyc_i - EscCntDw'(1);
    go_p0       = ((state_q == Idle) && accu_trig) ||
                  ((state_q == Timeout) && bus.en_i &&
                   (accu_trig || (esc_cnt_q >= timeout_lim)));
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= Idle;
      esc_cnt_q  <= '0;
      esc_trig_q <= 1'b0;
`ifdef ESC_CLR_LOCK_EN
      lock_q     <= 1'b0;
`endif
    end else begin
      esc_trig_q <= 1'b0;
      if (clr_eff) begin
        state_q   <= Idle;
        esc_cnt_q <= '0;
      end else begin
`ifdef ESC_CLR_LOCK_EN
        if (go_p0) lock_q <= 1'b1;
`endif
        unique case (state_q)
          Idle: begin
            if (go_p0) begin
              state_q    <= Phase0;
              esc_cnt_q  <= '0;
              esc_trig_q <= 1'b1;
            end else if (trig_q && (bus.timeout_cyc_i != '0)) begin
              state_q   <= Timeout;
              esc_cnt_q <= '0;
            end
          end
          Timeout: begin
            if (!bus.en_i) begin
              state_q   <= Idle;
              esc_cnt_q <= '0;
            end else if (go_p0) begin
              state_q    <= Phase0;
              esc_cnt_q  <= '0;
              esc_trig_q <= 1'b1;
            end else begin
              esc_cnt_q <= esc_cnt_inc(esc_cnt_q);
            end
          end
          Phase0, Phase1, Phase2, Phase3: begin
            if (esc_cnt_q >= phase_lim) begin
              state_q   <= (state_q == Phase3) ? Terminal : cstate_e'(state_q + 3'd1);
              esc_cnt_q <= '0;
            end else begin
              esc_cnt_q <= esc_cnt_inc(esc_cnt_q);
            end
          end
          Terminal: begin
            esc_cnt_q <= '0;
          end
          default: begin
            state_q   <= Idle;
            esc_cnt_q <= '0;
          end
        endcase
      end
    end
  end

  always_comb begin
    esc_sig = '0;
    for (int s = 0; s < N_ESC_SEV; s++) begin
      esc_sig[s] = bus.esc_en_i[s] & state_q[2] &
                   (state_q[1:0] == bus.esc_map_i[s*PHASE_DW +: PHASE_DW]);
    end
  end

  assign bus.esc_state_o = state_q;
  assign bus.esc_cnt_o   = esc_cnt_q;
  assign bus.esc_trig_o  = esc_trig_q;
  assign bus.esc_sig_o   = esc_sig;

endmodule

// File: doc/alert_handler_esc_timer.md
Name: alert_handler_esc_timer

Overview:
Per-class escalation engine. It consumes one class trigger from the alert classifier (class_trig_o[k]) and accumulates trigger events. When the count crosses a threshold, or a per-class interrupt timeout expires, it sequences through four timed escalation phases. One instance per class sits between the classifier and the escalation senders. The phase-to-severity mapping selects which escalation signals fire.

Parameters:
AccuCntDw, 16, accumulator counter width
EscCntDw, 32, timeout/phase cycle counter width
N_PHASES, 4, number of escalation phases (fixed to 4 by state encoding)
N_ESC_SEV, 4, number of escalation severity outputs
PHASE_DW, 2, width of a phase index in esc_map_i

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, synchronous, active-low
en_i  in  1  class enable
clr_i  in  1  class clear (single-cycle pulse)
class_trig_i  in  1  class trigger from classifier
accu_thresh_i  in  AccuCntDw  accumulation threshold
timeout_cyc_i  in  EscCntDw  interrupt timeout in cycles; 0 disables timeout
phase_cyc_i  in  N_PHASES*EscCntDw  per-phase duration, phase p at [p*EscCntDw +: EscCntDw]
esc_map_i  in  N_ESC_SEV*PHASE_DW  phase index that drives each severity
esc_en_i  in  N_ESC_SEV  per-severity enable
accu_cnt_o  out  AccuCntDw  accumulator value
esc_cnt_o  out  EscCntDw  timeout/phase counter value
esc_state_o  out  3  FSM state
esc_trig_o  out  1  one-cycle pulse on entry to Phase0
esc_sig_o  out  N_ESC_SEV  escalation signals

Behaviour:
- Reset (rst_ni=0 at a clk_i edge): state=Idle, accu_cnt_o=0, esc_cnt_o=0, esc_trig_o=0, esc_sig_o=0. A reset applied mid-escalation aborts the escalation immediately.
- State encoding: Idle=000, Timeout=001, Terminal=011, Phase0=100, Phase1=101, Phase2=110, Phase3=111. esc_state_o is the registered state.
- trig_q = en_i & class_trig_i.
- Accumulator: on trig_q, accu_cnt_o increments by 1 and saturates at all-ones (no wrap).
- accu_trig = trig_q & (accu_cnt_o >= accu_thresh_i). The comparison uses the pre-increment value. Example: thresh=2 means the third trigger escalates.
- clr_i has top priority. It forces state=Idle, accu_cnt_o=0 and esc_cnt_o=0. A trigger in the same cycle is discarded.
- Idle:
  - accu_trig -> Phase0.
  - Otherwise trig_q & (timeout_cyc_i != 0) -> Timeout.
  - esc_cnt_o is set to 0 on either transition.
- Timeout:
  - en_i=0 -> Idle.
  - accu_trig or esc_cnt_o >= timeout_cyc_i-1 -> Phase0, esc_cnt_o=0.
  - Otherwise esc_cnt_o+1.
- Phase p:
  - esc_cnt_o >= phase_cyc[p]-1 (a value of 0 is treated as 1) -> Phase p+1, esc_cnt_o=0. Phase3 advances to Terminal.
  - Otherwise esc_cnt_o+1.
  - en_i has no effect once a phase is entered.
- Terminal: holds with esc_cnt_o=0 until clr_i.
- esc_trig_o: registered, high for exactly the first cycle in Phase0.
- esc_sig_o[s] = esc_en_i[s] & state in {Phase0..Phase3} & (state[1:0] == esc_map_i[s]). This is a combinational decode of the registered state, so there is no added latency relative to esc_state_o.
- Counters never wrap. esc_cnt_o saturates at all-ones.

Optional Feature:
Macro ESC_CLR_LOCK_EN.
- Defined: a lock bit sets on entry to Phase0. While the lock is set, clr_i is ignored, so the FSM ends in Terminal and stays there until reset. Reset clears the lock.
- Undefined: clr_i aborts from any state, including phases and Terminal.

Decomposition:
- Shared package alert_handler_reg_pkg:
  - AccuCntDw, EscCntDw, N_PHASES, N_ESC_SEV, PHASE_DW
  - state enum cstate_e (the seven encodings above)
- Sub-module alert_handler_accu:
  - saturating accumulator plus threshold compare
  - inputs: clk_i, rst_ni, clr_i, trig_q, accu_thresh_i
  - outputs: accu_cnt_o, accu_trig
- The FSM and cycle counter stay in alert_handler_esc_timer.

Test Plan:
1. Accumulation escalation: thresh=2, timeout=0, all phase_cyc=3, esc_map={3,2,1,0}, esc_en=4'hF, three trig pulses.
   - esc_trig_o pulses in the cycle after the third trigger.
   - esc_sig_o is 4'b1000, 4'b0100, 4'b0010, 4'b0001 for 3 cycles each, then 0.
   - esc_state_o=011.
2. Timeout path: thresh=100, timeout=5, one trig.
   - Timeout state for 5 cycles, esc_cnt_o runs 0..4, then Phase0.
   - Repeat with en_i dropped at cycle 2: state returns to 000, no esc_trig_o.
3. Clear priority: clr_i and trig in the same cycle while in Phase1.
   - Next cycle state=000, accu_cnt_o=0, esc_sig_o=0.
   - With ESC_CLR_LOCK_EN defined, the state continues to Phase2.
4. Saturation: AccuCntDw=4, thresh=15, 20 triggers.
   - accu_cnt_o holds 15; escalation starts on the 16th trigger.
5. Zero phase length: phase_cyc={0,0,0,0}.
   - Each phase lasts exactly 1 cycle; Terminal is reached 4 cycles after Phase0 entry.
6. Reset in Phase2: rst_ni=0 for 1 cycle.
   - All outputs 0 and state=000 on the next edge.
